// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : shared types and constants for the pipeline hazard controller
// Revision   : 1.0
// ============================================================================
package hazard_pkg;

    localparam int          c_reg_w      = 5;
    localparam logic [31:0] c_nop        = 32'h0000_0000;
    localparam logic [5:0]  c_hlt_opcode = 6'h3F;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic               valid;
        logic [c_reg_w-1:0] rd;
    } sb_entry_t;

    function automatic logic is_hlt(input logic [31:0] instr);
        return instr[31:26] == c_hlt_opcode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sb.sv
`default_nettype none
// ============================================================================
// hazard_sb : in-flight destination scoreboard with RAW source match
// Revision  : 1.0
// ============================================================================
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk_x,
    input  logic               rst_n,
    input  logic               load_valid,
    input  logic [c_reg_w-1:0] load_rd,
    input  logic [c_reg_w-1:0] rs,
    input  logic               use_rs,
    input  logic [c_reg_w-1:0] rt,
    input  logic               use_rt,
    output logic               match
);

    sb_entry_t r_sb [DEPTH];
    logic      w_match;

    function automatic logic hit(input sb_entry_t e, input logic use_r,
                                 input logic [c_reg_w-1:0] r);
        return use_r && (r != '0) && e.valid && (e.rd == r);
    endfunction

    // Entry 0 is the youngest; the oldest slot simply falls off the end.
    always_ff @(posedge clk_x or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            r_sb[0] <= '{valid: load_valid, rd: load_rd};
            for (int i = 1; i < DEPTH; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit(r_sb[i], use_rs, rs) || hit(r_sb[i], use_rt, rt)) begin
                w_match = 1'b1;
            end
        end
    end

    assign match = w_match;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : RAW stall, branch flush and HLT control for an in-order pipe
// Revision    : 1.0
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int SB_DEPTH     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk_x,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [c_reg_w-1:0] id_rs,
    input  logic [c_reg_w-1:0] id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic               id_wr_en,
    input  logic [c_reg_w-1:0] id_rd,
    input  logic               id_halt,
    input  logic               ex_br_taken,
    output logic               stall,
    output logic               bubble,
    output logic               flush,
    output logic               halted
);

    localparam int c_cnt_w = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_match;
    logic               w_hazard;
    logic               w_issue;
    logic               w_load_valid;
    logic               w_stall;
    logic               w_bubble;
    logic               w_flush;
    logic               w_halted;

    assign w_hazard     = id_valid && w_match;
    assign w_load_valid = w_issue && !id_halt && id_wr_en && (id_rd != '0);

    hazard_sb #(
        .DEPTH      (SB_DEPTH)
    ) u_sb (
        .clk_x      (clk_x),
        .rst_n      (rst_n),
        .load_valid (w_load_valid),
        .load_rd    (id_rd),
        .rs         (id_rs),
        .use_rs     (id_use_rs),
        .rt         (id_rt),
        .use_rt     (id_use_rt),
        .match      (w_match)
    );

    always_ff @(posedge clk_x or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The branch-resolve cycle is the first squashed slot; the counter covers
    // the remaining FLUSH_CYCLES-1 slots spent in ST_FLUSH.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        w_flush     = 1'b0;
        w_halted    = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (ex_br_taken) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = c_cnt_w'(FLUSH_CYCLES - 1);
                    end
                end else if (w_hazard) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end else if (id_valid) begin
                    w_issue = 1'b1;
                    if (id_halt) begin
                        w_state_nxt = ST_HALT;
                    end
                end
            end
            ST_FLUSH: begin
                w_flush   = 1'b1;
                w_bubble  = 1'b1;
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == c_cnt_w'(1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
                w_halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, independent of ID inputs.
    assign stall  = rst_n & w_stall;
    assign bubble = rst_n & w_bubble;
    assign flush  = rst_n & w_flush;
    assign halted = rst_n & w_halted;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : directed + randomized bench with a cycle-history reference
// Revision       : 1.0
// ============================================================================
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int SB_DEPTH     = 4;
    localparam int FLUSH_CYCLES = 2;

    logic       clk_x       = 1'b0;
    logic       rst_n       = 1'b0;
    logic       id_valid    = 1'b0;
    logic [4:0] id_rs       = '0;
    logic [4:0] id_rt       = '0;
    logic       id_use_rs   = 1'b0;
    logic       id_use_rt   = 1'b0;
    logic       id_wr_en    = 1'b0;
    logic [4:0] id_rd       = '0;
    logic       id_halt     = 1'b0;
    logic       ex_br_taken = 1'b0;
    logic       stall, bubble, flush, halted;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(
        .SB_DEPTH     (SB_DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk_x       (clk_x),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_wr_en    (id_wr_en),
        .id_rd       (id_rd),
        .id_halt     (id_halt),
        .ex_br_taken (ex_br_taken),
        .stall       (stall),
        .bubble      (bubble),
        .flush       (flush),
        .halted      (halted)
    );

    always #5 clk_x = ~clk_x;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a register is busy if it was issued as a destination within
    // the last SB_DEPTH clock cycles (cycle-stamp arithmetic, no shift chain).
    int last_wr [32];
    int cyc          = 0;
    int m_flush_left = 0;
    bit m_halted     = 1'b0;
    bit p_wr_valid   = 1'b0;
    int p_wr_reg     = 0;
    int p_flush_left = 0;
    bit p_halted     = 1'b0;

    task automatic model_reset();
        cyc          = 0;
        m_flush_left = 0;
        m_halted     = 1'b0;
        p_wr_valid   = 1'b0;
        p_flush_left = 0;
        p_halted     = 1'b0;
        for (int r = 0; r < 32; r++) last_wr[r] = -1000;
    endtask

    function automatic bit busy(input logic [4:0] r);
        return (r != 5'd0) && ((cyc - last_wr[r]) <= SB_DEPTH);
    endfunction

    always @(negedge clk_x) begin
        bit e_st, e_bu, e_fl, e_ha, haz;
        e_st = 1'b0; e_bu = 1'b0; e_fl = 1'b0; e_ha = 1'b0;
        p_wr_valid   = 1'b0;
        p_flush_left = m_flush_left;
        p_halted     = m_halted;
        if (rst_n) begin
            haz = id_valid && ((id_use_rs && busy(id_rs)) || (id_use_rt && busy(id_rt)));
            if (m_halted) begin
                e_st = 1'b1; e_bu = 1'b1; e_ha = 1'b1;
            end else if (m_flush_left > 0) begin
                e_fl = 1'b1; e_bu = 1'b1;
                p_flush_left = m_flush_left - 1;
            end else if (ex_br_taken) begin
                e_fl = 1'b1; e_bu = 1'b1;
                p_flush_left = FLUSH_CYCLES - 1;
            end else if (haz) begin
                e_st = 1'b1; e_bu = 1'b1;
            end else if (id_valid) begin
                if (id_halt) p_halted = 1'b1;
                else if (id_wr_en && id_rd != 5'd0) begin
                    p_wr_valid = 1'b1;
                    p_wr_reg   = int'(id_rd);
                end
            end
        end
        chk("cyc_stall",  32'(stall),  32'(e_st));
        chk("cyc_bubble", 32'(bubble), 32'(e_bu));
        chk("cyc_flush",  32'(flush),  32'(e_fl));
        chk("cyc_halted", 32'(halted), 32'(e_ha));
    end

    always @(posedge clk_x) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            if (p_wr_valid) last_wr[p_wr_reg] = cyc;
            m_flush_left = p_flush_left;
            m_halted     = p_halted;
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk_x);
        #1;
    endtask

    task automatic set_id(input bit v, input logic [4:0] rs, input bit urs,
                          input logic [4:0] rt, input bit urt, input bit we,
                          input logic [4:0] rd, input bit hlt, input bit br);
        id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
        id_wr_en = we; id_rd = rd; id_halt = hlt; ex_br_taken = br;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, is_hlt(c_nop), 1'b0);
    endtask

    task automatic drain();
        nop();
        repeat (SB_DEPTH + 2) step();
    endtask

    initial begin
        int n;
        logic [31:0] instr;
        model_reset();
        rst_n = 1'b0;
        nop();
        repeat (2) step();
        #3;
        chk("reset_stall",  32'(stall),  32'd0);
        chk("reset_bubble", 32'(bubble), 32'd0);
        chk("reset_flush",  32'(flush),  32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Load R1, then add reading R1 back to back.
        set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd1, 0, 0);
        step();
        set_id(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #3;
            if (stall !== 1'b1) break;
            n++;
            step();
        end
        chk("raw_stall_cycles", 32'(n), 32'd4);
        step();
        drain();

        // Writes to R0 never create a dependency.
        set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0);
        step();
        set_id(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 0);
        n = 0;
        repeat (3) begin
            #3;
            if (stall === 1'b1) n++;
            step();
        end
        chk("r0_stall_cycles", 32'(n), 32'd0);
        drain();

        // Taken branch squashes a wrong-path R5 writer; a second taken in FLUSH is ignored.
        set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 1);
        #3; n = int'(flush);
        step();
        set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 1);
        #3; n += int'(flush);
        step();
        set_id(1, 5'd5, 1, 5'd5, 1, 0, 5'd0, 0, 0);
        #3; n += int'(flush);
        chk("flush_cycles", 32'(n), 32'd2);
        chk("squashed_r5_stall", 32'(stall), 32'd0);
        step();
        drain();

        // R4 producer followed by HLT.
        set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd4, 0, 0);
        step();
        instr = 32'hFFFF_0005;
        set_id(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, is_hlt(instr), 0);
        #3;
        chk("hlt_cycle_halted", 32'(halted), 32'd0);
        step();
        set_id(1, 5'd4, 1, 5'd0, 0, 1, 5'd6, 0, 0);
        #3;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_stall",  32'(stall),  32'd1);
        chk("halt_bubble", 32'(bubble), 32'd1);
        repeat (6) step();
        chk("halt_sticky", 32'(halted), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("halt_reset_halted", 32'(halted), 32'd0);
        chk("halt_reset_stall",  32'(stall),  32'd0);
        step();
        rst_n = 1'b1;
        drain();

        // Hazard and taken branch together, then reset during FLUSH.
        set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 0);
        step();
        set_id(1, 5'd7, 1, 5'd0, 0, 0, 5'd0, 0, 1);
        #3;
        chk("br_haz_flush", 32'(flush), 32'd1);
        chk("br_haz_stall", 32'(stall), 32'd0);
        step();
        set_id(1, 5'd7, 1, 5'd0, 0, 0, 5'd0, 0, 0);
        #1;
        chk("in_flush", 32'(flush), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("flush_reset_flush",  32'(flush),  32'd0);
        chk("flush_reset_stall",  32'(stall),  32'd0);
        chk("flush_reset_bubble", 32'(bubble), 32'd0);
        chk("flush_reset_halted", 32'(halted), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic over a small register set to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            set_id($urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                   5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                   $urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0 || (m_halted && $urandom_range(0, 5) == 0))
                rst_n = 1'b0;
            else
                rst_n = 1'b1;
            step();
        end

        rst_n = 1'b1;
        nop();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
